// File: rtl/sr_cond_pkg.sv
// Shared constants, the output-selection enum and the counter-width helper
// for the sr_cmd_conditioner block.
package sr_cond_pkg;

    localparam int CH_SET = 0;
    localparam int CH_CLR = 1;

    localparam int SYNC_STAGES_DEF     = 2;
    localparam int DEBOUNCE_CYCLES_DEF = 4;
    localparam int TIMEOUT_CYCLES_DEF  = 16;

    typedef enum logic [1:0] {
        OUT_IDLE,
        OUT_SET,
        OUT_CLR,
        OUT_CONFLICT
    } out_sel_e;

    function automatic int cnt_width(input int max_val);
        return $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/sr_debounce.sv
// One command channel: synchronizer, debounce counter, debounced level and
// rising-edge pulse of the debounced level.
module sr_debounce
    import sr_cond_pkg::*;
#(
    parameter int SYNC_STAGES     = SYNC_STAGES_DEF,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic rise,
    output logic counting
);

    localparam int CW = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync;
    logic [SYNC_STAGES-1:0] vld;
    logic                   synced;
    logic                   level;
    logic                   level_q;
    logic                   armed;
    logic [CW-1:0]          cnt;

    assign synced = sync[SYNC_STAGES-1];

    // vld marks when the chain holds real samples; a rise is only reported
    // once the input has been seen low after reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync    <= '0;
            vld     <= '0;
            armed   <= 1'b0;
            level   <= 1'b0;
            level_q <= 1'b0;
            cnt     <= '0;
        end else begin
            sync    <= {sync[SYNC_STAGES-2:0], raw};
            vld     <= {vld[SYNC_STAGES-2:0], 1'b1};
            armed   <= armed | (vld[SYNC_STAGES-1] & ~synced);
            level_q <= level;
            if (synced == level) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                level <= synced;
                cnt   <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign rise     = level & ~level_q & armed;
    assign counting = (cnt != '0);

endmodule

// File: rtl/sr_cmd_conditioner.sv
// Conditions raw set/clear requests into exclusive one-cycle s/r pulses.
// Optional auto-clear timeout enabled by defining SR_AUTO_CLEAR_EN.
module sr_cmd_conditioner
    import sr_cond_pkg::*;
#(
    parameter int SYNC_STAGES     = SYNC_STAGES_DEF,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int TIMEOUT_CYCLES  = TIMEOUT_CYCLES_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic set_raw,
    input  logic clr_raw,
    output logic s,
    output logic r,
    output logic conflict,
    output logic busy
);

    if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
        $error("SYNC_STAGES must be 2..4");
    end
    if (DEBOUNCE_CYCLES < 1) begin : g_bad_deb
        $error("DEBOUNCE_CYCLES must be >= 1");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_bad_tmo
        $error("TIMEOUT_CYCLES must be >= 1");
    end

    logic [1:0] edges;
    logic [1:0] counting;
    out_sel_e   sel;
    logic       r_next;

    sr_debounce #(
        .SYNC_STAGES    (SYNC_STAGES),
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_set_deb (
        .clk     (clk),
        .reset   (reset),
        .raw     (set_raw),
        .rise    (edges[CH_SET]),
        .counting(counting[CH_SET])
    );

    sr_debounce #(
        .SYNC_STAGES    (SYNC_STAGES),
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_clr_deb (
        .clk     (clk),
        .reset   (reset),
        .raw     (clr_raw),
        .rise    (edges[CH_CLR]),
        .counting(counting[CH_CLR])
    );

    always_comb begin
        sel = OUT_IDLE;
        case ({edges[CH_CLR], edges[CH_SET]})
            2'b01:   sel = OUT_SET;
            2'b10:   sel = OUT_CLR;
            2'b11:   sel = OUT_CONFLICT;
            default: sel = OUT_IDLE;
        endcase
    end

`ifdef SR_AUTO_CLEAR_EN
    localparam int TW = cnt_width(TIMEOUT_CYCLES);

    logic [TW-1:0] tmr;
    logic [TW-1:0] tmr_next;
    logic          auto_fire;

    // Auto-clear only fires on idle cycles, so a coincident clear edge yields
    // one r and a coincident set edge reloads instead.
    always_comb begin
        tmr_next  = tmr;
        auto_fire = 1'b0;
        case (sel)
            OUT_SET:      tmr_next = TW'(TIMEOUT_CYCLES);
            OUT_CLR,
            OUT_CONFLICT: tmr_next = '0;
            default: begin
                if (tmr != '0) begin
                    tmr_next  = tmr - 1'b1;
                    auto_fire = (tmr == TW'(1));
                end
            end
        endcase
        r_next = (sel == OUT_CLR) || auto_fire;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tmr <= '0;
        end else begin
            tmr <= tmr_next;
        end
    end
`else
    always_comb begin
        r_next = (sel == OUT_CLR);
    end
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s        <= 1'b0;
            r        <= 1'b0;
            conflict <= 1'b0;
            busy     <= 1'b0;
        end else begin
            s        <= (sel == OUT_SET);
            r        <= r_next;
            conflict <= (sel == OUT_CONFLICT);
            busy     <= |counting;
        end
    end

endmodule

// File: tb/tb_sr_cmd_conditioner.sv
// Directed-vector bench for sr_cmd_conditioner (default parameters); the
// auto-clear vectors are included when SR_AUTO_CLEAR_EN is defined.
module tb_sr_cmd_conditioner;

    logic clk = 1'b0;
    logic reset;
    logic set_raw;
    logic clr_raw;
    logic s;
    logic r;
    logic conflict;
    logic busy;

    int vectors     = 0;
    int miscompares = 0;

    int idx, s_n, s_first, s_last, r_n, r_first, c_n, c_first, busy_seen, both_hi;

    sr_cmd_conditioner #(
        .SYNC_STAGES    (2),
        .DEBOUNCE_CYCLES(4),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .set_raw (set_raw),
        .clr_raw (clr_raw),
        .s       (s),
        .r       (r),
        .conflict(conflict),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input int got, input int exp);
        vectors++;
        if (got != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic clr_rec();
        idx = 0; s_n = 0; s_first = 0; s_last = 0; r_n = 0; r_first = 0;
        c_n = 0; c_first = 0; busy_seen = 0; both_hi = 0;
    endtask

    // Step one clock and log pulse positions relative to the window start.
    task automatic tick();
        @(posedge clk);
        #1;
        idx++;
        if (s) begin
            s_n++;
            if (s_n == 1) s_first = idx;
            s_last = idx;
        end
        if (r) begin
            r_n++;
            if (r_n == 1) r_first = idx;
        end
        if (conflict) begin
            c_n++;
            if (c_n == 1) c_first = idx;
        end
        if (busy) busy_seen = 1;
        if (s && r) both_hi++;
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    task automatic do_reset();
        reset   = 1'b1;
        set_raw = 1'b0;
        clr_raw = 1'b0;
        ticks(3);
        reset = 1'b0;
        ticks(4);
    endtask

    initial begin
        reset   = 1'b1;
        set_raw = 1'b1;
        clr_raw = 1'b0;
        clr_rec();

        // reset held with set_raw high, then release
        ticks(3);
        check_val("rst_s", s, 0);
        check_val("rst_r", r, 0);
        check_val("rst_conflict", conflict, 0);
        check_val("rst_busy", busy, 0);
        reset = 1'b0;
        clr_rec();
        ticks(30);
        check_val("rel_no_s", s_n, 0);
        check_val("rel_no_r", r_n, 0);
        set_raw = 1'b0;
        ticks(12);
        clr_rec();
        set_raw = 1'b1;
        ticks(20);
        check_val("rearm_s_count", s_n, 1);
        check_val("rearm_s_pos", s_first, 7);

        // clean set, held for a long time
        do_reset();
        clr_rec();
        set_raw = 1'b1;
        ticks(60);
        check_val("set_s_count", s_n, 1);
        check_val("set_s_pos", s_first, 7);
        check_val("set_conflict", c_n, 0);
        check_val("set_s_r_overlap", both_hi, 0);
`ifdef SR_AUTO_CLEAR_EN
        check_val("set_auto_r_count", r_n, 1);
        check_val("set_auto_r_pos", r_first, 23);
`else
        check_val("set_r_count", r_n, 0);
`endif

        // three-cycle glitch is rejected
        do_reset();
        clr_rec();
        set_raw = 1'b1;
        ticks(3);
        set_raw = 1'b0;
        ticks(15);
        check_val("glitch_s_count", s_n, 0);
        check_val("glitch_busy_seen", busy_seen, 1);
        check_val("glitch_busy_end", busy, 0);

        // clr bounce 1,0,1,0,1 then hold
        do_reset();
        clr_rec();
        clr_raw = 1'b1; tick();
        clr_raw = 1'b0; tick();
        clr_raw = 1'b1; tick();
        clr_raw = 1'b0; tick();
        clr_raw = 1'b1;
        ticks(20);
        check_val("bounce_r_count", r_n, 1);
        check_val("bounce_r_pos", r_first, 11);
        check_val("bounce_s_count", s_n, 0);

        // simultaneous rise
        do_reset();
        clr_rec();
        set_raw = 1'b1;
        clr_raw = 1'b1;
        ticks(20);
        check_val("sim_conflict_count", c_n, 1);
        check_val("sim_conflict_pos", c_first, 7);
        check_val("sim_s_count", s_n, 0);
        check_val("sim_r_count", r_n, 0);

`ifdef SR_AUTO_CLEAR_EN
        // second set pulse ten cycles after the first restarts the timeout
        do_reset();
        clr_rec();
        set_raw = 1'b1;
        ticks(6);
        set_raw = 1'b0;
        ticks(4);
        set_raw = 1'b1;
        ticks(30);
        check_val("reload_s_count", s_n, 2);
        check_val("reload_s_first", s_first, 7);
        check_val("reload_s_second", s_last, 17);
        check_val("reload_r_count", r_n, 1);
        check_val("reload_r_pos", r_first, 33);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
